regfile_port_seq: RTL and testbench
===================================

# regfile_port_seq

Multi-cycle sequencer that sits on the initiator side of the CPU register file. It accepts one MIPS-format instruction at a time, drives the two read addresses, and latches the operands. It then hands the operands to the execute stage, waits for the result and performs the single write-back cycle, with RegWr timed so the file's negedge write lands mid-cycle.

## Interface
Parameters:
- TIMEOUT, 64: max cycles spent in WAIT before abort (used only with watchdog compiled in).
- TW, 7: watchdog counter width, must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE; transfer when valid & ready.
- instr  in  32  instruction word.
- ReadReg1  out  5  register file read address A.
- ReadReg2  out  5  register file read address B.
- ReadData1  in  32  combinational read data A.
- ReadData2  in  32  combinational read data B.
- RegWr  out  1  register file write enable.
- WriteReg  out  5  write address.
- WriteData  out  32  write data.
- op_valid  out  1  one-cycle pulse, operands valid.
- op_a, op_b  out  32 each  latched operands.
- op_instr  out  32  latched instruction.
- res_valid  in  1  one-cycle pulse from execute.
- res_data  in  32  result, valid with res_valid.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, READ, ISSUE, WAIT, WB.
- IDLE: instr_ready=1; on instr_valid, latch instr, go to READ.
- READ: ReadReg1=instr[25:21], ReadReg2=instr[20:16]; at the posedge ending READ, latch ReadData1/2 into op_a/op_b, go to ISSUE.
- ISSUE: op_valid=1 for exactly this cycle; go to WAIT.
- Write target: opcode 0 uses instr[15:11], otherwise instr[20:16]. Write is disabled for opcodes 0x2B (sw), 0x04 (beq), 0x05 (bne), 0x02 (j), and whenever the target is 0.
- res_valid is sampled in ISSUE and WAIT; other states ignore it. On res_valid, latch res_data; go to WB if the write is enabled, else to IDLE.
- WB: RegWr=1, WriteReg/WriteData stable for the whole cycle; then IDLE.
- Read addresses are held at the latched values outside READ (no glitching). RegWr=0 in every state except WB.
- Reset mid-operation: immediate return to IDLE, in-flight write dropped, RegWr forced 0 asynchronously.
- Reset values: instr_ready=1 (IDLE), all other outputs 0.

## Timing
- Minimum occupancy: accept (cycle 0), READ (1), ISSUE (2), WB (3 when res_valid arrives in ISSUE); next accept at cycle 4.
- Execute latency L cycles after op_valid adds L cycles in WAIT.
- RegWr high for exactly one posedge-to-posedge cycle, so the register file's negedge write sees settled address and data.
- instr_valid during a non-IDLE state is ignored. No overlap between instructions.
- A second res_valid in the same instruction (after leaving WAIT) is ignored.

## Configuration
- REGFILE_SEQ_WATCHDOG_EN defined: a counter clears on entry to ISSUE and increments each WAIT cycle. When it reaches TIMEOUT without res_valid, the block pulses timeout_err for one cycle, drops the write and returns to IDLE. If res_valid and the timeout fall in the same cycle, res_valid wins.
- Not defined: WAIT waits indefinitely; timeout_err is tied to 0; no counter logic.

## Structure
- Package regfile_seq_pkg holds:
  - the state enum (IDLE, READ, ISSUE, WAIT, WB);
  - opcode constants OP_RTYPE=6'h00, OP_SW=6'h2B, OP_BEQ=6'h04, OP_BNE=6'h05, OP_J=6'h02;
  - the field slice positions.
- One sub-module, regfile_seq_watchdog (counter plus compare), instantiated only under REGFILE_SEQ_WATCHDOG_EN.

## Test plan
- add $3,$1,$2 (0x00221820), regs 1/2 preloaded 5/7, res_valid with 12 two cycles after op_valid -> op_a=5, op_b=7; one RegWr pulse with WriteReg=3, WriteData=12.
- sw (opcode 0x2B) with res_valid -> RegWr never asserted; instr_ready returns the cycle after res_valid.
- addi $0,$1,1 (rt=0) -> no write; next instruction accepted.
- rst low during WAIT, then res_valid pulse after release -> state IDLE, RegWr stays 0, no write occurs.
- Watchdog on, TIMEOUT=64, no res_valid -> timeout_err pulse exactly 64 WAIT cycles after op_valid, no write. Watchdog off -> still in WAIT at cycle 200.
- Back-to-back instr_valid held high -> accepts spaced by full occupancy (4 cycles with res_valid in ISSUE); ReadReg1/2 stable outside READ.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file port sequencer:
// FSM state encoding, MIPS opcode values, instruction field positions and
// the write-back decode helpers.
package regfile_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4
    } seq_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // R-type results land in rd, everything else in rt.
    function automatic logic [4:0] wb_target(input logic [5:0] opcode,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
        return (opcode == OP_RTYPE) ? rd : rt;
    endfunction

    // Stores, branches and jumps produce no register result; $0 is never written.
    function automatic logic wb_enable(input logic [5:0] opcode,
                                       input logic [4:0] target);
        return !(opcode == OP_SW || opcode == OP_BEQ ||
                 opcode == OP_BNE || opcode == OP_J) && (target != 5'd0);
    endfunction

endpackage

// File: rtl/regfile_seq_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting for the execute result and
// flags the last permitted cycle. Only built when REGFILE_SEQ_WATCHDOG_EN is
// defined.
module regfile_seq_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    // Clear when the sequencer is about to issue, count every WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // During WAIT cycle k the count holds k-1, so this fires in the
    // TIMEOUT-th WAIT cycle.
    assign expire_o = inc_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/regfile_port_seq.sv
// Register-file initiator sequencer: accepts one instruction, reads its two
// source registers, hands operands to execute, waits for the result and
// performs a single write-back cycle.
// Optional watchdog on the WAIT state: define REGFILE_SEQ_WATCHDOG_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | instr_ready high, waiting for an instruction
// READ  | read addresses driven from latched rs/rt, operands captured at end
// ISSUE | op_valid pulse; an immediate res_valid is accepted here
// WAIT  | waiting for res_valid (optionally bounded by the watchdog)
// WB    | RegWr high for the whole cycle with stable address and data
module regfile_port_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  ReadReg1,
    output logic [4:0]  ReadReg2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    output logic        RegWr,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        op_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_instr,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        timeout_err
);

    if ((2 ** TW) <= TIMEOUT) begin : g_cfg_check
        $error("regfile_port_seq: watchdog width TW too small for TIMEOUT");
    end

    seq_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwr_q;
    logic        timeout_pulse;
    logic        wd_expire;

    logic [5:0]  opcode;
    logic [4:0]  wr_target;
    logic        wr_en;

    assign opcode    = instr_q[OP_MSB:OP_LSB];
    assign wr_target = wb_target(opcode, instr_q[RT_MSB:RT_LSB], instr_q[RD_MSB:RD_LSB]);
    assign wr_en     = wb_enable(opcode, wr_target);

`ifdef REGFILE_SEQ_WATCHDOG_EN
    regfile_seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_d == ISSUE),
        .inc_i    (state_q == WAIT),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state and datapath capture decisions.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        wdata_d       = wdata_q;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: begin
                op_a_d  = ReadData1;
                op_b_d  = ReadData2;
                state_d = ISSUE;
            end
            ISSUE, WAIT: begin
                if (res_valid) begin
                    wdata_d = res_data;
                    state_d = wr_en ? WB : IDLE;
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end else if (wd_expire) begin
                    timeout_pulse = 1'b1;
                    state_d       = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; RegWr is registered so it cannot glitch
    // around the register file's negedge write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            wdata_q <= '0;
            regwr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            wdata_q <= wdata_d;
            regwr_q <= (state_d == WB);
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign op_valid    = (state_q == ISSUE);
    assign ReadReg1    = instr_q[RS_MSB:RS_LSB];
    assign ReadReg2    = instr_q[RT_MSB:RT_LSB];
    assign RegWr       = regwr_q;
    assign WriteReg    = wr_target;
    assign WriteData   = wdata_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_instr    = instr_q;
    assign timeout_err = timeout_pulse;

endmodule

// File: tb/tb_regfile_port_seq.sv
// Directed testbench for regfile_port_seq with a behavioural register file
// (combinational read, negedge write). Watchdog scenario follows
// REGFILE_SEQ_WATCHDOG_EN.
module tb_regfile_port_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  ReadReg1, ReadReg2;
    logic [31:0] ReadData1, ReadData2;
    logic        RegWr;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        op_valid;
    logic [31:0] op_a, op_b, op_instr;
    logic        res_valid;
    logic [31:0] res_data;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [31:0] rf [0:31];

    regfile_port_seq #(.TIMEOUT(64), .TW(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .RegWr       (RegWr),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_instr    (op_instr),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    always @(negedge clk) begin
        if (RegWr === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            if (WriteReg != 5'd0) rf[WriteReg] = WriteData;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", instr_ready); end
        checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL reset_regwr: got %0b expected 0", RegWr); end
        checks++; if (op_valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got op_valid=%0b timeout_err=%0b expected 0/0", op_valid, timeout_err); end
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0 || op_instr !== 32'h0 || WriteData !== 32'h0) begin failures++; $display("FAIL reset_data: got a=%0h b=%0h instr=%0h wd=%0h expected all 0", op_a, op_b, op_instr, WriteData); end
        checks++; if (ReadReg1 !== 5'd0 || ReadReg2 !== 5'd0 || WriteReg !== 5'd0) begin failures++; $display("FAIL reset_addr: got rr1=%0d rr2=%0d wr=%0d expected 0", ReadReg1, ReadReg2, WriteReg); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_add();
        int w0 = wr_cnt;
        instr = 32'h00221820; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if (ReadReg1 !== 5'd1 || ReadReg2 !== 5'd2) begin failures++; $display("FAIL add_readaddr: got %0d/%0d expected 1/2", ReadReg1, ReadReg2); end
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL add_busy: got %0b expected 0", instr_ready); end
        step();
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL add_opvalid: got %0b expected 1", op_valid); end
        checks++; if (op_a !== 32'd5 || op_b !== 32'd7) begin failures++; $display("FAIL add_operands: got %0d/%0d expected 5/7", op_a, op_b); end
        checks++; if (op_instr !== 32'h00221820) begin failures++; $display("FAIL add_opinstr: got %0h expected 00221820", op_instr); end
        step();
        checks++; if (op_valid !== 1'b0 || RegWr !== 1'b0) begin failures++; $display("FAIL add_wait1: got op_valid=%0b RegWr=%0b expected 0/0", op_valid, RegWr); end
        step();
        res_valid = 1'b1; res_data = 32'd12;
        step();
        res_valid = 1'b0;
        checks++; if (RegWr !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'd12) begin failures++; $display("FAIL add_wb: got RegWr=%0b reg=%0d data=%0d expected 1/3/12", RegWr, WriteReg, WriteData); end
        step();
        checks++; if (RegWr !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL add_done: got RegWr=%0b ready=%0b expected 0/1", RegWr, instr_ready); end
        checks++; if (wr_cnt !== w0 + 1 || rf[3] !== 32'd12) begin failures++; $display("FAIL add_write: got writes=%0d rf3=%0d expected %0d/12", wr_cnt - w0, rf[3], 1); end
    endtask

    task automatic test_store();
        int w0 = wr_cnt;
        instr = 32'hAC220004; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL sw_opvalid: got %0b expected 1", op_valid); end
        res_valid = 1'b1; res_data = 32'd99;
        step();
        res_valid = 1'b0;
        checks++; if (instr_ready !== 1'b1 || RegWr !== 1'b0) begin failures++; $display("FAIL sw_return: got ready=%0b RegWr=%0b expected 1/0", instr_ready, RegWr); end
        res_valid = 1'b1; res_data = 32'd98;
        step();
        res_valid = 1'b0;
        step();
        checks++; if (wr_cnt !== w0 || instr_ready !== 1'b1) begin failures++; $display("FAIL sw_nowrite: got writes=%0d ready=%0b expected 0/1", wr_cnt - w0, instr_ready); end
    endtask

    task automatic test_zero_target();
        int w0 = wr_cnt;
        instr = 32'h20200001; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        res_valid = 1'b1; res_data = 32'd55;
        step();
        res_valid = 1'b0;
        checks++; if (instr_ready !== 1'b1 || RegWr !== 1'b0) begin failures++; $display("FAIL r0_return: got ready=%0b RegWr=%0b expected 1/0", instr_ready, RegWr); end
        instr = 32'h00222020; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        res_valid = 1'b1; res_data = 32'd77;
        step();
        res_valid = 1'b0;
        checks++; if (RegWr !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'd77) begin failures++; $display("FAIL r0_next_wb: got RegWr=%0b reg=%0d data=%0d expected 1/4/77", RegWr, WriteReg, WriteData); end
        step();
        checks++; if (wr_cnt !== w0 + 1 || rf[4] !== 32'd77 || rf[0] !== 32'd0) begin failures++; $display("FAIL r0_writes: got writes=%0d rf4=%0d rf0=%0d expected 1/77/0", wr_cnt - w0, rf[4], rf[0]); end
    endtask

    task automatic test_reset_mid();
        int w0 = wr_cnt;
        instr = 32'h00222820; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1 || RegWr !== 1'b0 || op_a !== 32'd0) begin failures++; $display("FAIL rstmid_async: got ready=%0b RegWr=%0b op_a=%0d expected 1/0/0", instr_ready, RegWr, op_a); end
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        res_valid = 1'b1; res_data = 32'hDEAD;
        step();
        res_valid = 1'b0;
        checks++; if (instr_ready !== 1'b1 || RegWr !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got ready=%0b RegWr=%0b expected 1/0", instr_ready, RegWr); end
        step();
        checks++; if (wr_cnt !== w0 || rf[5] !== 32'd0) begin failures++; $display("FAIL rstmid_nowrite: got writes=%0d rf5=%0h expected 0/0", wr_cnt - w0, rf[5]); end
    endtask

    task automatic test_timeout();
        int w0 = wr_cnt;
        int bad = 0;
        instr = 32'h00223020; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL to_opvalid: got %0b expected 1", op_valid); end
`ifdef REGFILE_SEQ_WATCHDOG_EN
        for (int i = 1; i < 64; i++) begin
            step();
            if (timeout_err !== 1'b0 || instr_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL to_early: got %0d early cycles expected 0", bad); end
        step();
        checks++; if (timeout_err !== 1'b1 || RegWr !== 1'b0) begin failures++; $display("FAIL to_pulse: got timeout_err=%0b RegWr=%0b expected 1/0", timeout_err, RegWr); end
        step();
        checks++; if (timeout_err !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL to_idle: got timeout_err=%0b ready=%0b expected 0/1", timeout_err, instr_ready); end
        step();
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL to_nowrite: got writes=%0d expected 0", wr_cnt - w0); end
`else
        for (int i = 3; i <= 200; i++) begin
            step();
            if (timeout_err !== 1'b0 || instr_ready !== 1'b0 || RegWr !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL nowd_waiting: got %0d non-WAIT cycles expected 0", bad); end
        res_valid = 1'b1; res_data = 32'h66;
        step();
        res_valid = 1'b0;
        checks++; if (RegWr !== 1'b1 || WriteReg !== 5'd6 || WriteData !== 32'h66) begin failures++; $display("FAIL nowd_wb: got RegWr=%0b reg=%0d data=%0h expected 1/6/66", RegWr, WriteReg, WriteData); end
        step();
        checks++; if (wr_cnt !== w0 + 1 || instr_ready !== 1'b1) begin failures++; $display("FAIL nowd_done: got writes=%0d ready=%0b expected 1/1", wr_cnt - w0, instr_ready); end
`endif
    endtask

    task automatic test_back_to_back();
        int          w0 = wr_cnt;
        int          acc_cyc [3];
        int          accepts = 0;
        int          rr_bad = 0;
        logic        prev_ready;
        logic [4:0]  prev_rr1, prev_rr2;
        logic [31:0] issue3_a = 32'h0;
        logic [31:0] issue3_b = 32'h0;
        logic [31:0] seq [3];
        seq[0] = 32'h00223820;
        seq[1] = 32'h00414020;
        seq[2] = 32'h00644820;
        for (int k = 0; k < 3; k++) acc_cyc[k] = -1;
        instr = seq[0]; instr_valid = 1'b1;
        prev_ready = 1'b1; prev_rr1 = ReadReg1; prev_rr2 = ReadReg2;
        for (int cyc = 0; cyc < 13; cyc++) begin
            res_valid = op_valid;
            res_data  = 32'h100 + 32'(cyc);
            if (!prev_ready && (ReadReg1 !== prev_rr1 || ReadReg2 !== prev_rr2)) rr_bad++;
            if (op_valid === 1'b1 && cyc == 10) begin
                issue3_a = op_a;
                issue3_b = op_b;
            end
            if (instr_ready === 1'b1 && accepts < 3) begin
                acc_cyc[accepts] = cyc;
                accepts++;
            end
            prev_ready = instr_ready; prev_rr1 = ReadReg1; prev_rr2 = ReadReg2;
            step();
            if (prev_ready) begin
                if (accepts < 3) instr = seq[accepts];
                else instr_valid = 1'b0;
            end
        end
        res_valid = 1'b0;
        checks++; if (acc_cyc[0] != 0 || acc_cyc[1] != 4 || acc_cyc[2] != 8) begin failures++; $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 0,4,8", acc_cyc[0], acc_cyc[1], acc_cyc[2]); end
        checks++; if (rr_bad != 0) begin failures++; $display("FAIL b2b_readaddr_stable: got %0d changes expected 0", rr_bad); end
        checks++; if (issue3_a !== 32'd12 || issue3_b !== 32'd77) begin failures++; $display("FAIL b2b_operands: got %0d/%0d expected 12/77", issue3_a, issue3_b); end
        checks++; if (rf[7] !== 32'h102 || rf[8] !== 32'h106 || rf[9] !== 32'h10A) begin failures++; $display("FAIL b2b_results: got %0h/%0h/%0h expected 102/106/10a", rf[7], rf[8], rf[9]); end
        checks++; if (wr_cnt !== w0 + 3) begin failures++; $display("FAIL b2b_writes: got %0d expected 3", wr_cnt - w0); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst = 1'b0;
        instr_valid = 1'b0;
        instr = 32'h0;
        res_valid = 1'b0;
        res_data = 32'h0;
        test_reset();
        test_add();
        test_store();
        test_zero_target();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
